dport_arb: RTL
==============

Name: dport_arb

Overview:
Two-requester arbiter that shares one data-port (mem_d style) target between two masters, for example the core dport and a debug/DMA master feeding dport_mux. It round-robins requests onto the single downstream port and holds a granted request stable until the target accepts it. It records the issuing master of every accepted request in an in-order outstanding FIFO and routes each downstream response (ack/error/data/tag) back to that master with zero added latency.

Parameters:
OUTSTANDING, 4, maximum accepted-but-unacknowledged downstream requests (power of 2, 2..16)
OUTSTANDING_W, 2, log2(OUTSTANDING)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low (0 = reset)
m0_addr_i / m1_addr_i  in  32  request address, masters 0/1
m0_data_wr_i / m1_data_wr_i  in  32  write data
m0_rd_i / m1_rd_i  in  1  read request
m0_wr_i / m1_wr_i  in  4  byte write strobes
m0_cacheable_i / m1_cacheable_i  in  1  cacheable attribute
m0_req_tag_i / m1_req_tag_i  in  11  request tag
m0_accept_o / m1_accept_o  out  1  request accepted this cycle
m0_ack_o / m1_ack_o  out  1  response valid for that master
m0_error_o / m1_error_o  out  1  response error
m0_data_rd_o / m1_data_rd_o  out  32  read data
m0_resp_tag_o / m1_resp_tag_o  out  11  response tag
mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o, mem_cacheable_o, mem_req_tag_o  out  32/32/1/4/1/11  downstream request
mem_accept_i  in  1  downstream accepted request
mem_ack_i, mem_error_i  in  1/1  downstream response, in order
mem_data_rd_i, mem_resp_tag_i  in  32/11  downstream response data/tag

Behaviour:
- reqN = mN_rd_i | (|mN_wr_i). Request fires when mem_(rd|wr) asserted and mem_accept_i=1.
- Issue is allowed only when count_q < OUTSTANDING; if FIFO full: mem_rd_o=0, mem_wr_o=0, all mN_accept_o=0.
- Arbitration (unlocked): one requester -> it wins. Both request -> master != last_q wins. Winner is muxed combinationally onto mem_*_o with zero latency. mem_* outputs are 0 when nothing is granted.
- Lock: if granted request presented but mem_accept_i=0, set locked_q=1, owner_q=winner. While locked, owner_q is granted regardless of the other master until accept. The locked master must hold its request stable (protocol rule; not checked). Clear lock on accept.
- On fire: mN_accept_o=1 for granted master only; last_q<=granted; push granted ID into FIFO; count_q+1.
- Response: on mem_ack_i, head ID selects the master. That master's ack_o=1 and error/data_rd/resp_tag are passed through; the pop is combinational, count_q-1. Non-selected master: ack_o=0, data/tag/error=0.
- Simultaneous push and pop: count_q unchanged, both pointers advance; a request issued in the same cycle the FIFO goes full-to-non-full is still blocked (full check uses count_q).
- mem_ack_i with count_q=0: dropped, no master acked, state unchanged (protocol violation).
- Pointers wrap modulo OUTSTANDING; count_q width OUTSTANDING_W+1.
- Reset (rst_i=0 at clk edge): count_q=0, rd/wr ptr=0, locked_q=0, owner_q=0, last_q=1 (master 0 wins first tie). All outputs derive combinationally: every accept/ack/mem_* output is 0 while no requests are present. Reset mid-transaction discards outstanding IDs; later acks are dropped.
- No combinational path from mN_*_i to mN_accept_o other than through mem_accept_i/grant; no path from mem_ack_i to any mem_*_o.

Test Plan:
- Reset, m0 read addr 0x80000010 tag 0x005, mem_accept_i=1, ack next cycle with data 0xDEADBEEF -> mem_addr_o=0x80000010 same cycle, m0_accept_o=1, next cycle m0_ack_o=1, data 0xDEADBEEF, tag 0x005, m1_ack_o=0.
- Both request continuously, target always accepts -> grants alternate m0,m1,m0,m1 (m0 first after reset).
- m1 granted, mem_accept_i=0 for 3 cycles while m0 also requests -> m1 held on mem_* for all 3 cycles, m1_accept_o on the 4th, m0 granted next.
- OUTSTANDING=4, 4 accepted with no acks -> 5th request sees mem_rd_o=0, m*_accept_o=0; one ack -> issue resumes the following cycle.
- Interleaved issue m0,m1,m1,m0 then 4 in-order acks with errors on the 2nd -> acks routed m0,m1,m1,m0; m1_error_o=1 on the 2nd only.
- Reset asserted with 2 outstanding, then a spurious mem_ack_i -> no m*_ack_o, count_q=0, first grant goes to m0.

Source files
------------

// File: rtl/dport_arb.sv
// Two-master round-robin arbiter onto one mem_d style data port.
// An in-order FIFO of issuing-master IDs steers each downstream response back to its requester.
module dport_arb #(
    parameter int OUTSTANDING   = 4,
    parameter int OUTSTANDING_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_cacheable_i,
    input  logic [10:0] m0_req_tag_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_rd_o,
    output logic [10:0] m0_resp_tag_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic        m1_cacheable_i,
    input  logic [10:0] m1_req_tag_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,
    output logic [10:0] m1_resp_tag_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic        mem_cacheable_o,
    output logic [10:0] mem_req_tag_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic [10:0] mem_resp_tag_i
);

    localparam int CNT_W = OUTSTANDING_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

    logic [CNT_W-1:0]         count_q, count_d;
    logic [OUTSTANDING_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUTSTANDING_W-1:0] rd_ptr_q, rd_ptr_d;
    logic                     locked_q, locked_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     fifo_q [OUTSTANDING];

    logic req0, req1, full, gnt_valid, gnt_id, fire, pop, head_id;

    assign req0 = m0_rd_i | (|m0_wr_i);
    assign req1 = m1_rd_i | (|m1_wr_i);
    assign full = (count_q == FULL_CNT);

    // A stalled grant stays with its owner until accepted, whatever the other master does.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!full) begin
            if (locked_q) begin
                gnt_valid = owner_q ? req1 : req0;
                gnt_id    = owner_q;
            end else if (req0 && req1) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign fire        = gnt_valid & mem_accept_i;
    assign m0_accept_o = fire & ~gnt_id;
    assign m1_accept_o = fire & gnt_id;

    always_comb begin
        mem_addr_o      = '0;
        mem_data_wr_o   = '0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = '0;
        mem_cacheable_o = 1'b0;
        mem_req_tag_o   = '0;
        if (gnt_valid) begin
            if (gnt_id) begin
                mem_addr_o      = m1_addr_i;
                mem_data_wr_o   = m1_data_wr_i;
                mem_rd_o        = m1_rd_i;
                mem_wr_o        = m1_wr_i;
                mem_cacheable_o = m1_cacheable_i;
                mem_req_tag_o   = m1_req_tag_i;
            end else begin
                mem_addr_o      = m0_addr_i;
                mem_data_wr_o   = m0_data_wr_i;
                mem_rd_o        = m0_rd_i;
                mem_wr_o        = m0_wr_i;
                mem_cacheable_o = m0_cacheable_i;
                mem_req_tag_o   = m0_req_tag_i;
            end
        end
    end

    // Acks arriving with nothing outstanding are dropped rather than popped.
    assign pop     = mem_ack_i & (count_q != '0);
    assign head_id = fifo_q[rd_ptr_q];

    always_comb begin
        m0_ack_o      = pop & ~head_id;
        m1_ack_o      = pop & head_id;
        m0_error_o    = m0_ack_o ? mem_error_i    : 1'b0;
        m1_error_o    = m1_ack_o ? mem_error_i    : 1'b0;
        m0_data_rd_o  = m0_ack_o ? mem_data_rd_i  : '0;
        m1_data_rd_o  = m1_ack_o ? mem_data_rd_i  : '0;
        m0_resp_tag_o = m0_ack_o ? mem_resp_tag_i : '0;
        m1_resp_tag_o = m1_ack_o ? mem_resp_tag_i : '0;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        last_d   = last_q;
        if (fire) begin
            wr_ptr_d = wr_ptr_q + OUTSTANDING_W'(1);
            last_d   = gnt_id;
            locked_d = 1'b0;
        end else if (gnt_valid) begin
            locked_d = 1'b1;
            owner_d  = gnt_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + OUTSTANDING_W'(1);
        end
        case ({fire, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            fifo_q[wr_ptr_q] <= gnt_id;
        end
    end

endmodule
